// File: rtl/branch_resolve_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_resolve_arbiter_pkg                                           |
// | Shared branch-resolution types for the resolve arbiter slice.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

package branch_resolve_arbiter_pkg;

    localparam int BR_ARB_BUF_DEPTH = 4;
    localparam int ADDR_WIDTH       = 32;

    typedef logic [`B_MASK_WIDTH-1:0] B_MASK;
    typedef logic [ADDR_WIDTH-1:0]    ADDR;

    typedef struct packed {
        B_MASK bmm;
        logic  bm_mispred;
        ADDR   target_pc;
    } BRANCH_REG_PACKET;

    typedef struct packed {
        logic  valid;
        B_MASK bmm;
        B_MASK b_mask;
        logic  mispred;
        ADDR   target_pc;
    } BR_FU_RESULT_PACKET;

    typedef struct packed {
        B_MASK bmm;
        B_MASK b_mask;
        logic  mispred;
        ADDR   target_pc;
    } BR_ARB_SLOT;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_arbiter_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_oldest_select                                                     |
// | One-hot pick: oldest mispredict first, else lowest valid index.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module br_oldest_select
    import branch_resolve_arbiter_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0]  valid_i,
    input  B_MASK [N-1:0] bmm_i,
    input  B_MASK [N-1:0] b_mask_i,
    input  logic [N-1:0]  mispred_i,
    output logic [N-1:0]  sel_o
);

    logic [N-1:0] mp;
    logic [N-1:0] oldest;
    logic [N-1:0] pick;

    always_comb begin
        B_MASK older_mp;
        older_mp = '0;
        mp       = valid_i & mispred_i;
        oldest   = '0;
        // A mispredict is oldest when no other mispredict sits in its age mask
        for (int i = 0; i < N; i++) begin
            older_mp = '0;
            for (int j = 0; j < N; j++) begin
                if (j != i && mp[j]) begin
                    older_mp = older_mp | bmm_i[j];
                end
            end
            oldest[i] = mp[i] & ~(|(b_mask_i[i] & older_mp));
        end
        if (|oldest) begin
            pick = oldest;
        end else if (|mp) begin
            pick = mp;
        end else begin
            pick = valid_i;
        end
        sel_o = pick & (~pick + N'(1));
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_resolve_arbiter                                               |
// | Buffers branch FU results, broadcasts one resolution per cycle.      |
// | Optional statistics counters: define BR_RESOLVE_STATS_EN.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_resolve_arbiter
    import branch_resolve_arbiter_pkg::*;
#(
    parameter int NUM_BR_FU = 2,
    parameter int BUF_DEPTH = BR_ARB_BUF_DEPTH
) (
    input  logic                                clock,
    input  logic                                reset,
    input  BR_FU_RESULT_PACKET [NUM_BR_FU-1:0]  fu_result,
    output logic                                fu_ready,
    output BRANCH_REG_PACKET                    branch_completing,
    output logic                                arb_busy
`ifdef BR_RESOLVE_STATS_EN
   ,output logic [31:0]                         stat_resolved,
    output logic [31:0]                         stat_mispred,
    output logic [31:0]                         stat_squashed
`endif
);

    localparam int NC    = BUF_DEPTH + NUM_BR_FU;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BUF_DEPTH - NUM_BR_FU);

    BR_ARB_SLOT [BUF_DEPTH-1:0] slot_q, slot_d;
    logic [BUF_DEPTH-1:0]       slot_vld_q, slot_vld_d;
    logic [CNT_W-1:0]           count_q, count_d;
    BRANCH_REG_PACKET           bc_q, bc_d;

    BR_ARB_SLOT [NC-1:0] cand;
    logic [NC-1:0]       cand_vld, k_kill, sel, squash, keep;
    B_MASK [NC-1:0]      cand_bmm, cand_bm;
    logic [NC-1:0]       cand_mp;

    assign fu_ready          = (count_q <= READY_MAX);
    assign arb_busy          = |slot_vld_q;
    assign branch_completing = bc_q;

    // Candidates are slots first, then FU ports, so index order is the tie-break order
    always_comb begin : p_filter
        cand     = '0;
        cand_vld = '0;
        k_kill   = '0;
        for (int s = 0; s < BUF_DEPTH; s++) begin
            k_kill[s]      = slot_vld_q[s] & bc_q.bm_mispred & (|(slot_q[s].b_mask & bc_q.bmm));
            cand_vld[s]    = slot_vld_q[s] & ~k_kill[s];
            cand[s]        = slot_q[s];
            cand[s].b_mask = slot_q[s].b_mask & ~bc_q.bmm;
        end
        for (int p = 0; p < NUM_BR_FU; p++) begin
            k_kill[BUF_DEPTH+p]   = fu_result[p].valid & fu_ready & bc_q.bm_mispred
                                  & (|(fu_result[p].b_mask & bc_q.bmm));
            cand_vld[BUF_DEPTH+p] = fu_result[p].valid & fu_ready & ~k_kill[BUF_DEPTH+p];
            cand[BUF_DEPTH+p].bmm       = fu_result[p].bmm;
            cand[BUF_DEPTH+p].b_mask    = fu_result[p].b_mask & ~bc_q.bmm;
            cand[BUF_DEPTH+p].mispred   = fu_result[p].mispred;
            cand[BUF_DEPTH+p].target_pc = fu_result[p].target_pc;
        end
    end

    for (genvar c = 0; c < NC; c++) begin : g_cand
        assign cand_bmm[c] = cand[c].bmm;
        assign cand_bm[c]  = cand[c].b_mask;
        assign cand_mp[c]  = cand[c].mispred;
    end

    br_oldest_select #(
        .N         (NC)
    ) u_select (
        .valid_i   (cand_vld),
        .bmm_i     (cand_bmm),
        .b_mask_i  (cand_bm),
        .mispred_i (cand_mp),
        .sel_o     (sel)
    );

    always_comb begin : p_update
        logic placed;
        placed = 1'b0;
        bc_d   = '0;
        for (int c = 0; c < NC; c++) begin
            if (sel[c]) begin
                bc_d.bmm        = cand[c].bmm;
                bc_d.bm_mispred = cand[c].mispred;
                bc_d.target_pc  = cand[c].target_pc;
            end
        end
        // A selected mispredict also kills its younger siblings before they reach storage
        for (int c = 0; c < NC; c++) begin
            squash[c] = cand_vld[c] & ~sel[c] & bc_d.bm_mispred & (|(cand[c].b_mask & bc_d.bmm));
        end
        keep       = cand_vld & ~sel & ~squash;
        slot_vld_d = keep[BUF_DEPTH-1:0];
        slot_d     = cand[BUF_DEPTH-1:0];
        for (int p = 0; p < NUM_BR_FU; p++) begin
            placed = 1'b0;
            for (int s = 0; s < BUF_DEPTH; s++) begin
                if (keep[BUF_DEPTH+p] && !placed && !slot_vld_d[s]) begin
                    slot_d[s]     = cand[BUF_DEPTH+p];
                    slot_vld_d[s] = 1'b1;
                    placed        = 1'b1;
                end
            end
        end
        count_d = '0;
        for (int s = 0; s < BUF_DEPTH; s++) begin
            count_d = count_d + CNT_W'(slot_vld_d[s]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q     <= '0;
            slot_vld_q <= '0;
            count_q    <= '0;
            bc_q       <= '0;
        end else begin
            slot_q     <= slot_d;
            slot_vld_q <= slot_vld_d;
            count_q    <= count_d;
            bc_q       <= bc_d;
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    localparam int KW = $clog2(NC + 1);

    logic [KW-1:0] kill_cnt;
    logic [31:0]   stat_resolved_q, stat_mispred_q, stat_squashed_q;

    always_comb begin
        kill_cnt = '0;
        for (int c = 0; c < NC; c++) begin
            kill_cnt = kill_cnt + KW'(k_kill[c] | squash[c]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
            stat_squashed_q <= '0;
        end else begin
            if (bc_q.bmm != '0 && stat_resolved_q != '1) begin
                stat_resolved_q <= stat_resolved_q + 32'd1;
            end
            if (bc_q.bmm != '0 && bc_q.bm_mispred && stat_mispred_q != '1) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
            if (stat_squashed_q > (32'hFFFF_FFFF - 32'(kill_cnt))) begin
                stat_squashed_q <= '1;
            end else begin
                stat_squashed_q <= stat_squashed_q + 32'(kill_cnt);
            end
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
    assign stat_squashed = stat_squashed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_branch_resolve_arbiter                                            |
// | Directed scenarios plus random traffic against a behavioural model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_branch_resolve_arbiter;
    import branch_resolve_arbiter_pkg::*;

    localparam int NFU   = 2;
    localparam int DEPTH = 4;

    logic                          clock = 1'b0;
    logic                          reset = 1'b1;
    BR_FU_RESULT_PACKET [NFU-1:0]  fu_result;
    logic                          fu_ready;
    logic                          arb_busy;
    BRANCH_REG_PACKET              branch_completing;
`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] stat_resolved, stat_mispred, stat_squashed;
`endif

    always #5 clock = ~clock;

    branch_resolve_arbiter #(.NUM_BR_FU(NFU), .BUF_DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .fu_result         (fu_result),
        .fu_ready          (fu_ready),
        .branch_completing (branch_completing),
        .arb_busy          (arb_busy)
`ifdef BR_RESOLVE_STATS_EN
       ,.stat_resolved     (stat_resolved),
        .stat_mispred      (stat_mispred),
        .stat_squashed     (stat_squashed)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    typedef struct {
        bit        v;
        bit [3:0]  bmm;
        bit [3:0]  bm;
        bit        mp;
        bit [31:0] pc;
    } ent_t;

    ent_t      ms[DEPTH];
    int        mcount = 0;
    bit [3:0]  k_bmm  = '0;
    bit        k_mp   = 1'b0;
    bit [31:0] k_pc   = '0;

    function automatic bit m_ready();
        return (DEPTH - mcount) >= NFU;
    endfunction

    function automatic bit m_busy();
        return mcount != 0;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit(string nm, logic [63:0] dut_v, logic [63:0] mdl_v, logic [63:0] exp);
        chk(nm, dut_v, exp);
        chk({"model ", nm}, mdl_v, exp);
    endtask

    // Reference: apply the resolution rules to an explicit candidate list
    task automatic model_step();
        ent_t c[DEPTH+NFU];
        ent_t nk;
        int   sel;
        bit   older, placed;
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) ms[s].v = 1'b0;
            mcount = 0; k_bmm = '0; k_mp = 1'b0; k_pc = '0;
            return;
        end
        for (int s = 0; s < DEPTH; s++) c[s] = ms[s];
        for (int p = 0; p < NFU; p++) begin
            c[DEPTH+p].v   = fu_result[p].valid && m_ready();
            c[DEPTH+p].bmm = fu_result[p].bmm;
            c[DEPTH+p].bm  = fu_result[p].b_mask;
            c[DEPTH+p].mp  = fu_result[p].mispred;
            c[DEPTH+p].pc  = fu_result[p].target_pc;
        end
        for (int i = 0; i < DEPTH+NFU; i++) begin
            if (c[i].v && k_mp && (c[i].bm & k_bmm) != 0) c[i].v = 1'b0;
            c[i].bm = c[i].bm & ~k_bmm;
        end
        sel = -1;
        for (int i = 0; i < DEPTH+NFU; i++) begin
            if (c[i].v && c[i].mp) begin
                older = 1'b1;
                for (int j = 0; j < DEPTH+NFU; j++)
                    if (j != i && c[j].v && c[j].mp && (c[i].bm & c[j].bmm) != 0) older = 1'b0;
                if (older && sel < 0) sel = i;
            end
        end
        for (int i = 0; i < DEPTH+NFU; i++)
            if (sel < 0 && c[i].v) sel = i;
        nk = '{v: 1'b0, bmm: 4'b0, bm: 4'b0, mp: 1'b0, pc: 32'b0};
        if (sel >= 0) begin
            nk = c[sel];
            c[sel].v = 1'b0;
            if (nk.mp)
                for (int i = 0; i < DEPTH+NFU; i++)
                    if (c[i].v && (c[i].bm & nk.bmm) != 0) c[i].v = 1'b0;
        end
        for (int s = 0; s < DEPTH; s++) ms[s] = c[s];
        for (int p = 0; p < NFU; p++) begin
            placed = 1'b0;
            for (int s = 0; s < DEPTH; s++)
                if (c[DEPTH+p].v && !placed && !ms[s].v) begin
                    ms[s] = c[DEPTH+p];
                    placed = 1'b1;
                end
        end
        mcount = 0;
        for (int s = 0; s < DEPTH; s++) if (ms[s].v) mcount++;
        k_bmm = (sel >= 0) ? nk.bmm : 4'b0;
        k_mp  = (sel >= 0) ? nk.mp  : 1'b0;
        k_pc  = (sel >= 0) ? nk.pc  : 32'b0;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("branch_completing", 64'(branch_completing), 64'({k_bmm, k_mp, k_pc}));
            chk("fu_ready", 64'(fu_ready), 64'(m_ready()));
            chk("arb_busy", 64'(arb_busy), 64'(m_busy()));
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        #2;
    endtask

    task automatic idle();
        fu_result = '0;
    endtask

    task automatic drv(int p, bit [3:0] bmm, bit [3:0] bm, bit mp);
        fu_result[p] = '{valid: 1'b1, bmm: bmm, b_mask: bm, mispred: mp, target_pc: $urandom};
    endtask

    bit [3:0] po[$];
    bit [3:0] issued = '0;

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        lit("reset bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'd0);
        lit("reset fu_ready", 64'(fu_ready), 64'(m_ready()), 64'd1);
        lit("reset arb_busy", 64'(arb_busy), 64'(m_busy()), 64'd0);
        reset = 1'b0;

        // single correct result
        drv(0, 4'b0001, 4'b0000, 1'b0); tick(); idle();
        lit("single bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'b0001);
        lit("single mispred", 64'(branch_completing.bm_mispred), 64'(k_mp), 64'd0);
        tick();
        lit("single idle bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'd0);
        lit("single fu_ready", 64'(fu_ready), 64'(m_ready()), 64'd1);

        // two mispredicts in one cycle: older wins, younger squashed
        drv(0, 4'b0100, 4'b0011, 1'b1); drv(1, 4'b0010, 4'b0001, 1'b1); tick(); idle();
        lit("dual mp bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'b0010);
        lit("dual mp mispred", 64'(branch_completing.bm_mispred), 64'(k_mp), 64'd1);
        lit("dual mp busy", 64'(arb_busy), 64'(m_busy()), 64'd0);
        tick();
        lit("dual mp after", 64'(branch_completing.bmm), 64'(k_bmm), 64'd0);

        // buffered drain with mask clearing
        drv(0, 4'b0001, 4'b0000, 1'b0); drv(1, 4'b0010, 4'b0001, 1'b0); tick(); idle();
        lit("drain c1 bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'b0001);
        lit("drain c1 busy", 64'(arb_busy), 64'(m_busy()), 64'd1);
        tick();
        lit("drain c2 bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'b0010);
        lit("drain c2 busy", 64'(arb_busy), 64'(m_busy()), 64'd0);

        // buffered younger entry removed by mispredict, late arrival killed by K
        drv(0, 4'b0001, 4'b0000, 1'b0); drv(1, 4'b1000, 4'b0100, 1'b0); tick(); idle();
        lit("kill c1 bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'b0001);
        lit("kill c1 busy", 64'(arb_busy), 64'(m_busy()), 64'd1);
        drv(0, 4'b0100, 4'b0000, 1'b1); tick(); idle();
        lit("kill c2 bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'b0100);
        lit("kill c2 busy", 64'(arb_busy), 64'(m_busy()), 64'd0);
        drv(1, 4'b0010, 4'b0100, 1'b0); tick(); idle();
        lit("kill c3 bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'd0);
        lit("kill c3 busy", 64'(arb_busy), 64'(m_busy()), 64'd0);
        tick();
        lit("kill c4 bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'd0);

        // backpressure
        drv(0, 4'b0001, 4'b0000, 1'b0); drv(1, 4'b0010, 4'b0000, 1'b0); tick(); idle();
        drv(0, 4'b0100, 4'b0000, 1'b0); drv(1, 4'b1000, 4'b0000, 1'b0); tick(); idle();
        lit("bp c2 bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'b0010);
        drv(0, 4'b0001, 4'b0000, 1'b0); drv(1, 4'b0010, 4'b0000, 1'b0); tick(); idle();
        lit("bp c3 bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'b0100);
        lit("bp c3 fu_ready", 64'(fu_ready), 64'(m_ready()), 64'd0);
        tick();
        lit("bp c4 bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'b0001);
        lit("bp c4 fu_ready", 64'(fu_ready), 64'(m_ready()), 64'd1);
        drv(0, 4'b0001, 4'b0000, 1'b0); drv(1, 4'b0100, 4'b0000, 1'b0); tick(); idle();
        lit("bp c5 bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'b1000);
        lit("bp c5 fu_ready", 64'(fu_ready), 64'(m_ready()), 64'd0);

        // reset with three entries pending and a valid output
        reset = 1'b1; tick(); reset = 1'b0;
        lit("mid reset bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'd0);
        lit("mid reset busy", 64'(arb_busy), 64'(m_busy()), 64'd0);
        lit("mid reset fu_ready", 64'(fu_ready), 64'(m_ready()), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("post reset bmm", 64'(branch_completing.bmm), 64'(k_bmm), 64'd0);
        end

        // random traffic with legal, age-consistent masks
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (k_bmm != 0) begin
                int idx;
                idx = -1;
                foreach (po[i]) if (po[i] == k_bmm) idx = i;
                if (idx >= 0) begin
                    if (k_mp) begin
                        while (po.size() > idx) begin
                            issued = issued & ~po[po.size()-1];
                            void'(po.pop_back());
                        end
                    end else begin
                        issued = issued & ~po[idx];
                        po.delete(idx);
                    end
                end
            end
            idle();
            reset = 1'b0;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                po.delete();
                issued = '0;
            end else begin
                if (po.size() < 4 && $urandom_range(0, 1) == 1) begin
                    bit [3:0] fr[$];
                    for (int t = 0; t < 4; t++) begin
                        bit [3:0] tg;
                        bit       used;
                        tg = 4'(1 << t);
                        used = (tg == k_bmm);
                        foreach (po[i]) if (po[i] == tg) used = 1'b1;
                        if (!used) fr.push_back(tg);
                    end
                    if (fr.size() > 0) po.push_back(fr[$urandom_range(0, fr.size()-1)]);
                end
                if (m_ready()) begin
                    for (int p = 0; p < NFU; p++) begin
                        if ($urandom_range(0, 2) != 0) begin
                            int cands[$];
                            foreach (po[i]) if ((issued & po[i]) == 0) cands.push_back(i);
                            if (cands.size() > 0) begin
                                int       ix;
                                bit [3:0] bm;
                                ix = cands[$urandom_range(0, cands.size()-1)];
                                bm = '0;
                                for (int j = 0; j < ix; j++) bm = bm | po[j];
                                drv(p, po[ix], bm, $urandom_range(0, 4) == 0);
                                issued = issued | po[ix];
                            end
                        end
                    end
                end
            end
            tick();
        end
        idle();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_arbiter.md
Name: branch_resolve_arbiter

Overview:
- Sits between the branch functional units and the branch stack.
- Collects branch results from NUM_BR_FU branch FUs and buffers them.
- Each cycle, broadcasts at most one resolution as a registered BRANCH_REG_PACKET, which is the branch stack's branch_completing input.
- Mispredicts go first, oldest first. Buffered results younger than a broadcast mispredict are killed, and resolved bits are cleared from surviving masks.

Parameters:
- NUM_BR_FU, 2, number of branch FU result ports.
- BUF_DEPTH, 4, pending-result slots; must be >= NUM_BR_FU.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- fu_result  in  NUM_BR_FU x BR_FU_RESULT_PACKET  per port: valid, bmm (one-hot own bit), b_mask (older unresolved branches), mispred, target_pc (ADDR).
- fu_ready  out  1  arbiter can accept a full set of NUM_BR_FU results this cycle.
- branch_completing  out  BRANCH_REG_PACKET  bmm (one-hot, 0 when idle), bm_mispred, target_pc.
- arb_busy  out  1  at least one buffer slot valid.

Behaviour:
- Storage: BUF_DEPTH unordered slots, each holding {valid, bmm, b_mask, mispred, target_pc}, plus a registered occupancy count.
- fu_ready = (BUF_DEPTH - count) >= NUM_BR_FU. It uses registered state only and has no combinational path from fu_result.
  - fu_result[i].valid while fu_ready=0 is a protocol violation; the result is dropped.
- Define K = branch_completing as currently registered.
- Candidate set each cycle = valid slots + valid fu_result ports, after the K filtering below.
- Filtering against K (same cycle that K is driven):
  - If K.bm_mispred=1: any slot or incoming result with (b_mask & K.bmm)!=0 is discarded. This includes a result whose own bmm is younger than K.
  - If K.bmm!=0: bit K.bmm is cleared from every surviving slot and incoming b_mask.
- Selection, in priority order:
  - (a) Mispredict candidates first. Pick the candidate c with (c.b_mask & OR of other mispredict candidates' bmm)==0, i.e. the oldest. Ties break by lowest slot index, then lowest FU port.
  - (b) Otherwise, the lowest-index valid slot.
  - (c) Otherwise, the lowest FU port.
- Output register: the selected candidate becomes branch_completing on the next clock (latency 1 from selection). With no candidate, next branch_completing = 0.
- Buffer update: remove the selected entry. Write unselected incoming results into the lowest free slots. count = survivors after filtering and selection.
- Same-cycle mispredict selection: the selected mispredict m also squashes candidates younger than m in the same cycle (b_mask & m.bmm != 0). They are neither written nor kept. This guarantees a killed branch never appears on branch_completing.
- Duplicate bmm in flight: illegal; no checking required.
- Reset: all slot valid bits = 0, count = 0, branch_completing = 0, fu_ready = 1, arb_busy = 0. Reset mid-operation drops all pending results with no output.
- Width rule: count is $clog2(BUF_DEPTH+1) bits and never exceeds BUF_DEPTH.

Optional Feature:
- Macro: BR_RESOLVE_STATS_EN.
- With it: adds outputs stat_resolved and stat_mispred (32-bit each, saturating), incremented when branch_completing.bmm!=0 (and bm_mispred=1 for stat_mispred). Also adds stat_squashed (32-bit), incremented by the number of entries killed per cycle. All three reset to 0.
- Without it: these ports and counters do not exist.

Decomposition:
- sys_defs package: BR_FU_RESULT_PACKET typedef, BR_ARB_BUF_DEPTH constant; reuse B_MASK, ADDR, BRANCH_REG_PACKET, `B_MASK_WIDTH.
- One sub-module, br_oldest_select: combinational. Takes the candidate vector (bmm, b_mask, mispred, valid) and returns a one-hot select per the priority rules. It is verifiable standalone.

Test Plan:
All cases use B_MASK_WIDTH=4 and NUM_BR_FU=2.
- Single correct: fu0 {bmm=0001, b_mask=0000, mispred=0} -> next cycle branch_completing {bmm=0001, bm_mispred=0}; following cycle bmm=0000; fu_ready stays 1.
- Two mispredicts same cycle: fu0 {bmm=0100, b_mask=0011, mispred=1}, fu1 {bmm=0010, b_mask=0001, mispred=1} -> output bmm=0010 mispred=1; fu0 result squashed (0100 never output); buffer empty.
- Buffered drain with clearing: cycle 0 fu0 {0001, 0000, correct}, fu1 {0010, 0001, correct} -> cycle 1 outputs 0001. The buffered 0010 entry has b_mask cleared to 0000 and is output in cycle 2.
- Squash of buffered entry by K: buffer holds {bmm=1000, b_mask=0100}; K={bmm=0100, mispred=1} -> entry removed, count decrements, 1000 never output.
- Backpressure: fill to count=3 with BUF_DEPTH=4 and no drain opportunity -> fu_ready=0. Once count<=2, fu_ready=1.
- Reset mid-operation: count=3 with output valid, assert reset one cycle -> next cycle branch_completing=0, arb_busy=0, fu_ready=1, and no stale entry emerges afterwards.
